axis_demux_1to2: RTL and testbench
==================================

Name: axis_demux_1to2

Overview:
- AXI-Stream transmitter side of the 2:1 select path: takes one byte stream from an upstream source and forwards each packet to one of two downstream sinks.
- Route is chosen by `sel` on the first beat of a packet and locked until that packet's Tlast beat is accepted.
- One registered output stage with full-throughput backpressure.
- Per-output completed-packet counters for debug.

Parameters:
- DATA_W, 8, width of Tdata on all stream ports
- CNT_W, 8, width of the per-output packet counters (wrap-around)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- sel  input  1  route request: 0 -> output 0, 1 -> output 1; sampled only on the first beat of a packet
- s_Tdata  input  DATA_W  upstream data
- s_Tvalid  input  1  upstream valid
- s_Tlast  input  1  upstream last beat of packet
- s_Tready  output  1  ready to upstream
- m0_Tdata  output  DATA_W  output 0 data
- m0_Tvalid  output  1  output 0 valid
- m0_Tlast  output  1  output 0 last
- m0_Tready  input  1  output 0 ready
- m1_Tdata  output  DATA_W  output 1 data
- m1_Tvalid  output  1  output 1 valid
- m1_Tlast  output  1  output 1 last
- m1_Tready  input  1  output 1 ready
- busy  output  1  1 while a packet is open (route locked)
- pkt_cnt0  output  CNT_W  packets completed on output 0
- pkt_cnt1  output  CNT_W  packets completed on output 1

Behaviour:
- Reset (reset==0 at clk edge):
  - buffer empty, FSM IDLE, route=0, counters=0.
  - s_Tready forced 0 while reset is low.
  - All m*_Tvalid=0; m*_Tdata/Tlast=0; busy=0.
- Output stage: one register {data, last, dest, full}.
  - m0_Tvalid = full & (dest==0); m1_Tvalid = full & (dest==1).
  - Both m*_Tdata/m*_Tlast are driven from the register; the non-selected output's valid is 0.
- Ready: s_Tready = reset & (!full | sel_ready), where sel_ready = dest ? m1_Tready : m0_Tready.
  - The ready of the output not currently addressed is ignored.
- Accept: beat accepted when s_Tvalid & s_Tready. Data appears on the outputs the next cycle (latency 1).
- Drain: the register empties when the addressed m*_Tvalid & m*_Tready.
  - Accept and drain in the same cycle reload the register with no bubble, sustaining 1 beat/cycle.
- AXI rule: while m*_Tvalid=1 and ready=0, data/last/dest are held stable.
- FSM:
  - IDLE: on accept, dest=sel, route=sel. If s_Tlast=0, go to PKT; else stay IDLE (single-beat packet).
  - PKT: on accept, dest=route and `sel` is ignored. If s_Tlast=1, go to IDLE.
  - busy = (state==PKT).
- Sel change mid-packet has no effect on the current packet. A new sel takes effect on the first beat after Tlast, including a beat accepted in the very next cycle.
- Counters: pkt_cnt0/1 increment by 1 when a beat with last=1 drains to output 0/1. Wrap to 0 after 2^CNT_W-1. No saturation.
- Reset mid-packet: the buffered beat is discarded, FSM returns to IDLE, and the partial packet is not counted. Upstream must restart the packet.
- s_Tvalid=0 in PKT: the FSM holds, with no timeout.

Decomposition:
- Shared package `axis_pkg`:
  - FSM state encoding (IDLE=1'b0, PKT=1'b1)
  - route constants (ROUTE_M0=0, ROUTE_M1=1)
  - default DATA_W.
- Sub-module `axis_out_slice`: single-entry register slice holding {data, last, dest}, with the full flag, load/drain logic and pass-through ready.
- FSM, route lock and counters stay in the top.

Test Plan:
- Route to output 0: reset low 2 cycles, then sel=0, send 3 beats 0x11,0x22,0x33 (last on 0x33), m0_Tready=1.
  - Expect m0 to carry 0x11,0x22,0x33 one cycle after each accept, Tlast on 0x33.
  - m1_Tvalid stays 0; pkt_cnt0=1; busy high for beats 1-2 only.
- Route lock: sel=1 on beat 1 of 4 beats 0xA0..0xA3, sel toggled to 0 on beat 2.
  - All 4 beats appear on m1; pkt_cnt1=1.
  - The next packet with sel=0 goes to m0.
- Backpressure: sel=1, stream 0x01..0x04 with m1_Tready low for 3 cycles after the first beat lands.
  - m1_Tdata holds 0x01 stable and s_Tready=0 during the stall.
  - No beat lost or duplicated; m0_Tready toggling has no effect.
- Single-beat packets back-to-back: 0x55 (last, sel=0) then 0x66 (last, sel=1) on consecutive cycles, both readies high.
  - 0x55 on m0, 0x66 on m1 in consecutive cycles.
  - pkt_cnt0=1, pkt_cnt1=1; FSM never leaves IDLE.
- Reset mid-packet: sel=0, send 0x10 (no last), assert reset low one cycle while the register is full.
  - m0_Tvalid=0, busy=0, pkt_cnt0 unchanged, s_Tready=0 during reset.
  - The next packet follows the new sel.
- Counter wrap (CNT_W=2): send 5 single-beat packets to m1 -> pkt_cnt1 reads 1,2,3,0,1.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream 1:2 demux: FSM encoding, route
// constants and the default stream width.
package axis_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_e;

    localparam logic ROUTE_M0 = 1'b0;
    localparam logic ROUTE_M1 = 1'b1;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream byte channel (data, valid, last, ready) with master/slave views.
interface axis_if #(
    parameter int DATA_W = axis_pkg::DATA_W_DEF
) ();

    logic [DATA_W-1:0] Tdata;
    logic              Tvalid;
    logic              Tlast;
    logic              Tready;

    modport master (
        output Tdata,
        output Tvalid,
        output Tlast,
        input  Tready
    );

    modport slave (
        input  Tdata,
        input  Tvalid,
        input  Tlast,
        output Tready
    );

endinterface

// File: rtl/axis_out_slice.sv
// Single-entry output register {data, last, dest} feeding two AXI-Stream
// masters; only the addressed output's ready can free the entry.
module axis_out_slice
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic   clk,
    input  logic   reset,
    axis_if.slave  s,
    input  logic   dest_i,
    axis_if.master m0,
    axis_if.master m1,
    output logic   accept_o,
    output logic   drain_o,
    output logic   drain_last_o,
    output logic   drain_dest_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              dest_q, dest_d;
    logic              sel_ready;
    logic              in_ready;

    assign sel_ready = (dest_q == ROUTE_M1) ? m1.Tready : m0.Tready;
    assign in_ready  = reset & (~full_q | sel_ready);
    assign s.Tready  = in_ready;
    assign accept_o  = s.Tvalid & in_ready;
    assign drain_o   = full_q & sel_ready;

    assign drain_last_o = last_q;
    assign drain_dest_o = dest_q;

    assign m0.Tdata  = data_q;
    assign m0.Tlast  = last_q;
    assign m0.Tvalid = full_q & (dest_q == ROUTE_M0);
    assign m1.Tdata  = data_q;
    assign m1.Tlast  = last_q;
    assign m1.Tvalid = full_q & (dest_q == ROUTE_M1);

    // NOTE: every next-state signal gets its hold value first so no path
    // through this block can infer a latch.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        last_d = last_q;
        dest_d = dest_q;
        // A load while full only happens when the entry drains this cycle,
        // which keeps throughput at one beat per cycle with no bubble.
        if (accept_o) begin
            full_d = 1'b1;
            data_d = s.Tdata;
            last_d = s.Tlast;
            dest_d = dest_i;
        end else if (drain_o) begin
            full_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the payload
    // is reset as well so both outputs read zero straight after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            dest_q <= ROUTE_M0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            last_q <= last_d;
            dest_q <= dest_d;
        end
    end

endmodule

// File: rtl/axis_demux_1to2.sv
// AXI-Stream 1:2 packet demux: the route is taken from sel on a packet's first
// beat and held until its last beat is accepted; counts completed packets.
module axis_demux_1to2
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    axis_if.slave            s,
    axis_if.master           m0,
    axis_if.master           m1,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    state_e           state_q, state_d;
    logic             route_q, route_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             dest;
    logic             accept;
    logic             drain;
    logic             drain_last;
    logic             drain_dest;

    axis_out_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk          (clk),
        .reset        (reset),
        .s            (s),
        .dest_i       (dest),
        .m0           (m0),
        .m1           (m1),
        .accept_o     (accept),
        .drain_o      (drain),
        .drain_last_o (drain_last),
        .drain_dest_o (drain_dest)
    );

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        dest    = route_q;
        case (state_q)
            IDLE: begin
                dest = sel;
                if (accept) begin
                    route_d = sel;
                    if (!s.Tlast) begin
                        state_d = PKT;
                    end
                end
            end
            PKT: begin
                // sel is deliberately ignored until the packet closes.
                if (accept && s.Tlast) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // A packet is counted when its last beat leaves the slice, not when it
    // enters, so a reset mid-packet never counts the partial packet.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (drain && drain_last) begin
            if (drain_dest == ROUTE_M1) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            route_q <= ROUTE_M0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign busy     = (state_q == PKT);
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_demux_1to2.sv
// Self-checking bench for axis_demux_1to2: directed table, hand sequences for
// lock/backpressure/reset/wrap, then random traffic against a queue model.
module tb_axis_demux_1to2;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int CNT_M  = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       dest;
    } beat_t;

    typedef struct {
        logic       rst;
        logic       sel;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic       e_v1;
        logic [7:0] e_d;
        logic       e_l;
        logic       e_busy;
        logic [1:0] e_c0;
        logic [1:0] e_c1;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             sel;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;

    axis_if #(.DATA_W(DATA_W)) s_if ();
    axis_if #(.DATA_W(DATA_W)) m0_if ();
    axis_if #(.DATA_W(DATA_W)) m1_if ();

    axis_demux_1to2 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .s        (s_if),
        .m0       (m0_if),
        .m1       (m1_if),
        .busy     (busy),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;

    // reference model: a pending-beat queue plus packet/route bookkeeping
    beat_t pend[$];
    bit    in_pkt = 1'b0;
    bit    route = 1'b0;
    int    cnt0 = 0;
    int    cnt1 = 0;

    beat_t hd;
    bit    has, ev0, ev1, exp_ready, acc_m, drain_m;
    logic  cur_rst, cur_sel, cur_l;
    logic [7:0] cur_d;

    vec_t  vecs[11];
    int    wrap_exp[5] = '{1, 2, 3, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic sl, input logic v, input logic [7:0] d,
                         input logic l, input logic r0, input logic r1);
        reset        = rst;
        sel          = sl;
        s_if.Tvalid  = v;
        s_if.Tdata   = d;
        s_if.Tlast   = l;
        m0_if.Tready = r0;
        m1_if.Tready = r1;
        cur_rst = rst;
        cur_sel = sl;
        cur_l   = l;
        cur_d   = d;
        #1;
        has = (pend.size() != 0);
        if (has) hd = pend[0];
        else hd = '{data: 8'h00, last: 1'b0, dest: 1'b0};
        ev0       = has && !hd.dest;
        ev1       = has && hd.dest;
        exp_ready = rst && (!has || (hd.dest ? r1 : r0));
        acc_m     = v && exp_ready;
        drain_m   = has && (hd.dest ? r1 : r0);
    endtask

    task automatic check_model();
        if (chk_en) begin
            check("s_Tready", s_if.Tready, exp_ready);
            check("m0_Tvalid", m0_if.Tvalid, ev0);
            check("m1_Tvalid", m1_if.Tvalid, ev1);
            if (ev0) begin
                check("m0_Tdata", m0_if.Tdata, hd.data);
                check("m0_Tlast", m0_if.Tlast, hd.last);
            end
            if (ev1) begin
                check("m1_Tdata", m1_if.Tdata, hd.data);
                check("m1_Tlast", m1_if.Tlast, hd.last);
            end
            check("busy", busy, in_pkt);
            check("pkt_cnt0", pkt_cnt0, cnt0 & CNT_M);
            check("pkt_cnt1", pkt_cnt1, cnt1 & CNT_M);
        end
    endtask

    task automatic advance();
        beat_t b;
        @(posedge clk);
        if (!cur_rst) begin
            pend.delete();
            in_pkt = 1'b0;
            route  = 1'b0;
            cnt0   = 0;
            cnt1   = 0;
        end else begin
            if (drain_m) begin
                b = pend.pop_front();
                if (b.last) begin
                    if (b.dest) cnt1++;
                    else cnt0++;
                end
            end
            if (acc_m) begin
                b.data = cur_d;
                b.last = cur_l;
                b.dest = in_pkt ? route : cur_sel;
                route  = b.dest;
                in_pkt = !cur_l;
                pend.push_back(b);
            end
        end
        #1;
    endtask

    task automatic step(input logic rst, input logic sl, input logic v, input logic [7:0] d,
                        input logic l, input logic r0, input logic r1);
        drive(rst, sl, v, d, l, r0, r1);
        check_model();
        advance();
    endtask

    function automatic vec_t mk(input int rst, sl, v, d, l, r0, r1,
                                input int e_rdy, e_v0, e_v1, e_d, e_l, e_busy, e_c0, e_c1);
        vec_t x;
        x.rst = rst[0]; x.sel = sl[0]; x.v = v[0]; x.d = d[7:0]; x.l = l[0];
        x.r0 = r0[0]; x.r1 = r1[0];
        x.e_rdy = e_rdy[0]; x.e_v0 = e_v0[0]; x.e_v1 = e_v1[0]; x.e_d = e_d[7:0];
        x.e_l = e_l[0]; x.e_busy = e_busy[0]; x.e_c0 = e_c0[1:0]; x.e_c1 = e_c1[1:0];
        return x;
    endfunction

    initial begin
        int idx;
        reset = 1'b0; sel = 1'b0;
        s_if.Tvalid = 1'b0; s_if.Tdata = '0; s_if.Tlast = 1'b0;
        m0_if.Tready = 1'b1; m1_if.Tready = 1'b1;

        // rst sel v d l r0 r1 | rdy v0 v1 d l busy c0 c1
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 1, 1,  0, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 1, 8'h11, 0, 1, 1,  1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 8'h22, 0, 1, 1,  1, 1, 0, 8'h11, 0, 1, 0, 0);
        vecs[3]  = mk(1, 0, 1, 8'h33, 1, 1, 1,  1, 1, 0, 8'h22, 0, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'h33, 1, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 8'h00, 0, 1, 1,  1, 0, 0, 8'h00, 0, 0, 1, 0);
        vecs[6]  = mk(0, 1, 0, 8'h00, 0, 1, 1,  0, 0, 0, 8'h00, 0, 0, 1, 0);
        vecs[7]  = mk(1, 0, 1, 8'h55, 1, 1, 1,  1, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[8]  = mk(1, 1, 1, 8'h66, 1, 1, 1,  1, 1, 0, 8'h55, 1, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 8'h00, 0, 1, 1,  1, 0, 1, 8'h66, 1, 0, 1, 0);
        vecs[10] = mk(1, 0, 0, 8'h00, 0, 1, 1,  1, 0, 0, 8'h00, 0, 0, 1, 1);

        // first reset cycle: DUT state is still unknown, so nothing is compared
        step(0, 0, 0, 8'h00, 0, 1, 1);
        chk_en = 1'b1;

        // directed table: route to m0, then back-to-back single-beat packets
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].sel, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r0, vecs[i].r1);
            check($sformatf("vec%0d s_Tready", i), s_if.Tready, vecs[i].e_rdy);
            check($sformatf("vec%0d m0_Tvalid", i), m0_if.Tvalid, vecs[i].e_v0);
            check($sformatf("vec%0d m1_Tvalid", i), m1_if.Tvalid, vecs[i].e_v1);
            if (vecs[i].e_v0) begin
                check($sformatf("vec%0d m0_Tdata", i), m0_if.Tdata, vecs[i].e_d);
                check($sformatf("vec%0d m0_Tlast", i), m0_if.Tlast, vecs[i].e_l);
            end
            if (vecs[i].e_v1) begin
                check($sformatf("vec%0d m1_Tdata", i), m1_if.Tdata, vecs[i].e_d);
                check($sformatf("vec%0d m1_Tlast", i), m1_if.Tlast, vecs[i].e_l);
            end
            check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d pkt_cnt0", i), pkt_cnt0, vecs[i].e_c0);
            check($sformatf("vec%0d pkt_cnt1", i), pkt_cnt1, vecs[i].e_c1);
            check_model();
            advance();
        end

        // route lock: sel flips after the first beat, then a new packet follows at once
        step(1, 1, 1, 8'hA0, 0, 1, 1);
        step(1, 0, 1, 8'hA1, 0, 1, 1);
        step(1, 0, 1, 8'hA2, 0, 1, 1);
        step(1, 0, 1, 8'hA3, 1, 1, 1);
        step(1, 0, 1, 8'hB0, 1, 1, 1);
        step(1, 0, 0, 8'h00, 0, 1, 1);
        step(1, 0, 0, 8'h00, 0, 1, 1);
        check("lock pkt_cnt1", pkt_cnt1, 2);
        check("lock pkt_cnt0", pkt_cnt0, 2);

        // backpressure: m1 stalls for 3 cycles after the first beat lands
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1, (c == 0) ? 1'b1 : 1'($urandom_range(0, 1)), (idx < 4),
                  8'(idx + 1), (idx == 3), 1'($urandom_range(0, 1)), !(c >= 1 && c <= 3));
            if (c >= 1 && c <= 3) begin
                check("stall m1_Tdata", m1_if.Tdata, 8'h01);
                check("stall s_Tready", s_if.Tready, 1'b0);
            end
            check_model();
            if (acc_m) idx++;
            advance();
        end
        check("bp pkt_cnt1", pkt_cnt1, 3);

        // reset while a partial packet sits in the register
        step(1, 0, 1, 8'h10, 0, 0, 1);
        step(0, 0, 0, 8'h00, 0, 0, 1);
        check("rst m0_Tvalid", m0_if.Tvalid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst pkt_cnt0", pkt_cnt0, 0);
        step(1, 1, 1, 8'h77, 1, 1, 1);
        check("post-rst m1_Tvalid", m1_if.Tvalid, 1'b1);
        check("post-rst m1_Tdata", m1_if.Tdata, 8'h77);
        check("post-rst m0_Tvalid", m0_if.Tvalid, 1'b0);
        step(1, 0, 0, 8'h00, 0, 1, 1);

        // counter wrap on output 1
        step(0, 0, 0, 8'h00, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 1, 8'(8'hC0 + k), 1, 1, 1);
            step(1, 0, 0, 8'h00, 0, 1, 1);
            check($sformatf("wrap%0d pkt_cnt1", k), pkt_cnt1, wrap_exp[k]);
        end

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
